sprite_row_fetcher: RTL and testbench

Reads one scanline's row of a 4-bit palette-indexed sprite from a combinational sprite ROM (tank ROMs: 16-bit address, 4-bit data, row-major, index 0 = transparent). Each opaque pixel is written into the scanline line buffer at its screen x position. The block sits between the per-line sprite scheduler, which issues one start per visible sprite per line, and the line buffer that feeds the VGA colour mapper. It supports horizontal mirroring and right-edge clipping.

---
 rtl/sprite_row_fetcher.sv | 115 +++++++++++
 tb/tb_sprite_row_fetcher.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: walks one row of a 4-bit palette-indexed sprite in a
// combinational ROM and writes the opaque pixels into the scanline buffer.
// The ROM address and the pixel write are each registered, so the write for a
// column appears one cycle after its address. Supports mirroring and clips at
// the right screen edge.
module sprite_row_fetcher #(
  parameter int unsigned SPR_W = 48,
  parameter int unsigned SPR_H = 48,
  parameter int unsigned H_RES = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [5:0]  row,
  input  logic        mirror,
  input  logic [9:0]  dest_x,
  output logic [15:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [3:0]  pix_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e        state_q;
  logic [15:0]   row_base_q;
  logic          mirror_q;
  logic [9:0]    dest_q;
  logic [CW-1:0] c_q;

  logic [15:0]   row_base_in;
  logic [15:0]   first_addr;
  logic [CW-1:0] c_next;
  logic [15:0]   next_addr;
  logic [10:0]   x;
  logic          row_ok;
  logic          pix_vis;
  logic          last_col;

  // Address and pixel-stage arithmetic for the current column.
  always_comb begin
    row_base_in = base_addr + 16'(row) * 16'(SPR_W);
    first_addr  = row_base_in + (mirror ? 16'(SPR_W - 1) : 16'd0);
    c_next      = c_q + CW'(1);
    next_addr   = row_base_q + (mirror_q ? (16'(SPR_W - 1) - 16'(c_next)) : 16'(c_next));
    // 11-bit x so columns past the right edge never wrap back on screen.
    x           = 11'(dest_q) + 11'(c_q);
    row_ok      = 32'(row) < SPR_H;
    pix_vis     = (rom_data != 4'd0) && (32'(x) < H_RES);
    last_col    = (c_q == CW'(SPR_W - 1));
  end

  // Control FSM with registered ROM address, pixel stage and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_base_q <= 16'd0;
      mirror_q   <= 1'b0;
      dest_q     <= 10'd0;
      c_q        <= '0;
      rom_addr   <= 16'd0;
      pix_we     <= 1'b0;
      pix_x      <= 10'd0;
      pix_idx    <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (row_ok) begin
              state_q    <= StFetch;
              row_base_q <= row_base_in;
              mirror_q   <= mirror;
              dest_q     <= dest_x;
              c_q        <= '0;
              rom_addr   <= first_addr;
            end else begin
              // Row outside the sprite: report completion without touching the ROM.
              state_q <= StDrain;
              done    <= 1'b1;
            end
          end
        end
        StFetch: begin
          pix_we  <= pix_vis;
          pix_x   <= x[9:0];
          pix_idx <= rom_data;
          if (last_col) begin
            state_q <= StDrain;
            done    <= 1'b1;
          end else begin
            c_q      <= c_next;
            rom_addr <= next_addr;
          end
        end
        StDrain: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          pix_we  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher. Cycle 0 is the cycle whose closing
// edge accepts start; outputs are sampled on the falling edge of each cycle.
module tb_sprite_row_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [5:0]  row = 6'd0;
  logic        mirror = 1'b0;
  logic [9:0]  dest_x = 10'd0;
  logic [15:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pix_we;
  logic [9:0]  pix_x;
  logic [3:0]  pix_idx;
  logic        busy;
  logic        done;

  int          vecs = 0;
  int          errs = 0;
  int          rom_mode = 0;          // 0: every word is 8, 1: sparse single 9
  logic [15:0] sparse_addr = 16'd0;

  sprite_row_fetcher dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .row      (row),
    .mirror   (mirror),
    .dest_x   (dest_x),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix_we   (pix_we),
    .pix_x    (pix_x),
    .pix_idx  (pix_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // ROM model.
  always_comb begin
    rom_data = 4'h8;
    if (rom_mode == 1) rom_data = (rom_addr == sparse_addr) ? 4'h9 : 4'h0;
  end

  // Present a request during cycle 0; returns at the falling edge of cycle 1.
  task automatic issue(input logic [15:0] b, input logic [5:0] r, input logic m,
                       input logic [9:0] d);
    @(negedge clk);
    base_addr = b;
    row       = r;
    mirror    = m;
    dest_x    = d;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if ({rom_addr, pix_x, pix_idx, pix_we, busy, done} !== 33'd0) begin
      errs++;
      $display("FAIL reset_state: got addr=%h x=%0d idx=%h we=%b busy=%b done=%b want all 0",
               rom_addr, pix_x, pix_idx, pix_we, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({busy, done, pix_we} !== 3'b000) begin
      errs++;
      $display("FAIL reset_idle: got busy/done/we=%b want 000", {busy, done, pix_we});
    end
  endtask

  task automatic test_plain();
    logic [15:0] exp_addr;
    logic [2:0]  exp_ctl;
    rom_mode = 0;
    issue(16'd0, 6'd20, 1'b0, 10'd100);
    for (int k = 1; k <= 50; k++) begin
      exp_addr = (k <= 48) ? 16'(960 + k - 1) : 16'd1007;
      exp_ctl  = {k <= 49, k == 49, (k >= 2) && (k <= 49)};
      vecs++;
      if ({busy, done, pix_we} !== exp_ctl) begin
        errs++;
        $display("FAIL plain_ctl cycle %0d: got %b want %b", k, {busy, done, pix_we}, exp_ctl);
      end
      vecs++;
      if (rom_addr !== exp_addr) begin
        errs++;
        $display("FAIL plain_addr cycle %0d: got %0d want %0d", k, rom_addr, exp_addr);
      end
      if (exp_ctl[0]) begin
        vecs++;
        if ({pix_x, pix_idx} !== {10'(100 + k - 2), 4'h8}) begin
          errs++;
          $display("FAIL plain_pix cycle %0d: got x=%0d idx=%h want x=%0d idx=8",
                   k, pix_x, pix_idx, 100 + k - 2);
        end
      end
      if (k < 50) @(negedge clk);
    end
  endtask

  task automatic test_mirror();
    logic [15:0] exp_addr;
    rom_mode = 0;
    issue(16'h1000, 6'd0, 1'b1, 10'd0);
    for (int k = 1; k <= 50; k++) begin
      exp_addr = (k <= 48) ? 16'(16'h102F - (k - 1)) : 16'h1000;
      vecs++;
      if (rom_addr !== exp_addr) begin
        errs++;
        $display("FAIL mirror_addr cycle %0d: got %h want %h", k, rom_addr, exp_addr);
      end
      vecs++;
      if (pix_we !== ((k >= 2) && (k <= 49))) begin
        errs++;
        $display("FAIL mirror_we cycle %0d: got %b", k, pix_we);
      end
      if ((k >= 2) && (k <= 49)) begin
        vecs++;
        if (pix_x !== 10'(k - 2)) begin
          errs++;
          $display("FAIL mirror_x cycle %0d: got %0d want %0d", k, pix_x, k - 2);
        end
      end
      if (k < 50) @(negedge clk);
    end
  endtask

  task automatic test_transparency();
    logic [2:0] exp_ctl;
    rom_mode    = 1;
    sparse_addr = 16'h0205;
    issue(16'h0200, 6'd0, 1'b0, 10'd50);
    for (int k = 1; k <= 50; k++) begin
      exp_ctl = {k <= 49, k == 49, k == 7};
      vecs++;
      if ({busy, done, pix_we} !== exp_ctl) begin
        errs++;
        $display("FAIL transp_ctl cycle %0d: got %b want %b", k, {busy, done, pix_we}, exp_ctl);
      end
      if (k == 7) begin
        vecs++;
        if ({pix_x, pix_idx} !== {10'd55, 4'h9}) begin
          errs++;
          $display("FAIL transp_pix: got x=%0d idx=%h want x=55 idx=9", pix_x, pix_idx);
        end
      end
      if (k < 50) @(negedge clk);
    end
    rom_mode = 0;
  endtask

  task automatic test_clip();
    logic [2:0] exp_ctl;
    rom_mode = 0;
    issue(16'h0300, 6'd2, 1'b0, 10'd620);
    for (int k = 1; k <= 50; k++) begin
      exp_ctl = {k <= 49, k == 49, (k >= 2) && (k <= 21)};
      vecs++;
      if ({busy, done, pix_we} !== exp_ctl) begin
        errs++;
        $display("FAIL clip_ctl cycle %0d: got %b want %b", k, {busy, done, pix_we}, exp_ctl);
      end
      if (exp_ctl[0]) begin
        vecs++;
        if (pix_x !== 10'(620 + k - 2)) begin
          errs++;
          $display("FAIL clip_x cycle %0d: got %0d want %0d", k, pix_x, 620 + k - 2);
        end
      end
      if (k < 50) @(negedge clk);
    end
  endtask

  // Previous request ended with rom_addr = 0x0300 + 2*48 + 47 = 0x038F.
  task automatic test_out_of_range();
    issue(16'h5555, 6'd48, 1'b0, 10'd0);
    vecs++;
    if ({busy, done, pix_we, rom_addr} !== {3'b110, 16'h038F}) begin
      errs++;
      $display("FAIL oor_cycle1: got ctl=%b addr=%h want ctl=110 addr=038f",
               {busy, done, pix_we}, rom_addr);
    end
    @(negedge clk);
    vecs++;
    if ({busy, done, pix_we, rom_addr} !== {3'b000, 16'h038F}) begin
      errs++;
      $display("FAIL oor_cycle2: got ctl=%b addr=%h want ctl=000 addr=038f",
               {busy, done, pix_we}, rom_addr);
    end
  endtask

  // Extra starts at cycles 5 and 49 must be ignored; address wraps past 0xFFFF.
  task automatic test_back_to_back();
    logic [15:0] exp_addr;
    logic [2:0]  exp_ctl;
    issue(16'hFFF0, 6'd0, 1'b0, 10'd10);
    base_addr = 16'h1234;
    row       = 6'd3;
    mirror    = 1'b1;
    dest_x    = 10'd500;
    for (int k = 1; k <= 50; k++) begin
      exp_addr = (k <= 48) ? 16'(32'hFFF0 + k - 1) : 16'h001F;
      exp_ctl  = {k <= 49, k == 49, (k >= 2) && (k <= 49)};
      vecs++;
      if ({busy, done, pix_we} !== exp_ctl) begin
        errs++;
        $display("FAIL busy_ctl cycle %0d: got %b want %b", k, {busy, done, pix_we}, exp_ctl);
      end
      vecs++;
      if (rom_addr !== exp_addr) begin
        errs++;
        $display("FAIL busy_addr cycle %0d: got %h want %h", k, rom_addr, exp_addr);
      end
      if (exp_ctl[0]) begin
        vecs++;
        if (pix_x !== 10'(10 + k - 2)) begin
          errs++;
          $display("FAIL busy_x cycle %0d: got %0d want %0d", k, pix_x, 10 + k - 2);
        end
      end
      start = (k == 5) || (k == 49);
      if (k < 50) @(negedge clk);
    end
    // Cycle 50 is the earliest accept for the next row.
    base_addr = 16'd0;
    row       = 6'd1;
    mirror    = 1'b0;
    dest_x    = 10'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vecs++;
    if ({busy, rom_addr} !== {1'b1, 16'h0030}) begin
      errs++;
      $display("FAIL b2b_accept: got busy=%b addr=%h want busy=1 addr=0030", busy, rom_addr);
    end
    repeat (50) @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_finish: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_ctl;
    rom_mode = 0;
    issue(16'h0100, 6'd0, 1'b0, 10'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({rom_addr, pix_x, pix_idx, pix_we, busy, done} !== 33'd0) begin
      errs++;
      $display("FAIL rst_async: got addr=%h x=%0d idx=%h we=%b busy=%b done=%b want all 0",
               rom_addr, pix_x, pix_idx, pix_we, busy, done);
    end
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if ({busy, done, pix_we} !== 3'b000) begin
        errs++;
        $display("FAIL rst_hold: got %b want 000", {busy, done, pix_we});
      end
    end
    rst_n = 1'b1;
    issue(16'h0040, 6'd1, 1'b0, 10'd0);
    for (int k = 1; k <= 50; k++) begin
      exp_ctl = {k <= 49, k == 49, (k >= 2) && (k <= 49)};
      vecs++;
      if ({busy, done, pix_we} !== exp_ctl) begin
        errs++;
        $display("FAIL rst_refetch_ctl cycle %0d: got %b want %b", k, {busy, done, pix_we},
                 exp_ctl);
      end
      if (k <= 48) begin
        vecs++;
        if (rom_addr !== 16'(16'h0070 + k - 1)) begin
          errs++;
          $display("FAIL rst_refetch_addr cycle %0d: got %h want %h", k, rom_addr,
                   16'(16'h0070 + k - 1));
        end
      end
      if (exp_ctl[0]) begin
        vecs++;
        if (pix_x !== 10'(k - 2)) begin
          errs++;
          $display("FAIL rst_refetch_x cycle %0d: got %0d want %0d", k, pix_x, k - 2);
        end
      end
      if (k < 50) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_mirror();
    test_transparency();
    test_clip();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
